mem_access_stage: RTL and testbench

MEM pipeline stage: consumes the EX/MEM register outputs (ALU result/address, store data, write-back control) and performs data-memory loads/stores over a req/ack bus.
- Stalls upstream while an access is outstanding; aligns, extends and registers results for MEM/WB.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_access_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage performing aligned loads/stores over a req/ack bus.
// Optional watchdog on outstanding accesses enabled by defining MEM_TIMEOUT_EN.
`default_nettype none

module mem_access_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       data_in,
    input  logic [31:0]       store_data,
    input  logic [3:0]        mem_op,
    input  logic              reg_write_en_in,
    input  logic [4:0]        reg_addr_in,
    output logic              stall_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [31:0]       data_out,
    output logic              reg_write_en_out,
    output logic [4:0]        reg_addr_out,
    output logic              valid_out,
    output logic              align_err
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       data_q, data_d;
    logic              rwe_q, rwe_d;
    logic [4:0]        ra_q, ra_d;
    logic [31:0]       dout_q, dout_d;
    logic              dwe_q, dwe_d;
    logic [4:0]        dra_q, dra_d;
    logic              vout_q, vout_d;
    logic              aerr_q, aerr_d;

    logic              is_byte, is_half, is_word, is_store, is_mem, misaligned;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [ADDR_W-1:0] addr_full;
    logic [31:0]       load_result;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    always_comb begin
        is_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
        is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
        is_store = (mem_op == OP_SB) || (mem_op == OP_SH) || (mem_op == OP_SW);
        is_mem   = is_byte || is_half || is_word;
        misaligned = (is_half && data_in[0]) || (is_word && (data_in[1:0] != 2'b00));
    end

    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = 32'd0;
        if (is_byte) begin
            be_calc = 4'b0001 << data_in[1:0];
        end else if (is_half) begin
            be_calc = data_in[1] ? 4'b1100 : 4'b0011;
        end else if (is_word) begin
            be_calc = 4'b1111;
        end
        case (mem_op)
            OP_SB:   wdata_calc = {4{store_data[7:0]}};
            OP_SH:   wdata_calc = {2{store_data[15:0]}};
            OP_SW:   wdata_calc = store_data;
            default: wdata_calc = 32'd0;
        endcase
    end

    assign addr_full = data_in[ADDR_W-1:0];

    // Lane selection uses the byte offset captured with the request.
    always_comb begin
        ld_byte     = dmem_rdata[8*data_q[1:0] +: 8];
        ld_half     = data_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_result = dmem_rdata;
        case (op_q)
            OP_LB:   load_result = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_result = {24'd0, ld_byte};
            OP_LH:   load_result = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_result = {16'd0, ld_half};
            default: load_result = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit;
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        op_d      = op_q;
        data_d    = data_q;
        rwe_d     = rwe_q;
        ra_d      = ra_q;
        dout_d    = dout_q;
        dwe_d     = 1'b0;
        dra_d     = dra_q;
        vout_d    = 1'b0;
        aerr_d    = 1'b0;
        stall_req = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (valid_in && is_mem && misaligned) begin
                    vout_d = 1'b1;
                    aerr_d = 1'b1;
                    dout_d = data_in;
                    dra_d  = reg_addr_in;
                end else if (valid_in && is_mem) begin
                    stall_req = 1'b1;
                    state_d   = S_BUSY;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {addr_full[ADDR_W-1:2], 2'b00};
                    be_d      = be_calc;
                    wdata_d   = wdata_calc;
                    op_d      = mem_op;
                    data_d    = data_in;
                    rwe_d     = reg_write_en_in;
                    ra_d      = reg_addr_in;
                end else begin
                    dout_d = data_in;
                    dra_d  = reg_addr_in;
                    vout_d = valid_in;
                    dwe_d  = reg_write_en_in & valid_in;
                end
            end
            S_BUSY: begin
                stall_req = ~dmem_ack;
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    vout_d  = 1'b1;
                    dout_d  = we_q ? data_q : load_result;
                    dwe_d   = rwe_q;
                    dra_d   = ra_q;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_hit) begin
                    stall_req = 1'b0;
                    state_d   = S_IDLE;
                    req_d     = 1'b0;
                    vout_d    = 1'b1;
                    aerr_d    = 1'b1;
                    dra_d     = ra_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            op_q    <= 4'd0;
            data_q  <= 32'd0;
            rwe_q   <= 1'b0;
            ra_q    <= 5'd0;
            dout_q  <= 32'd0;
            dwe_q   <= 1'b0;
            dra_q   <= 5'd0;
            vout_q  <= 1'b0;
            aerr_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rwe_q   <= rwe_d;
            ra_q    <= ra_d;
            dout_q  <= dout_d;
            dwe_q   <= dwe_d;
            dra_q   <= dra_d;
            vout_q  <= vout_d;
            aerr_q  <= aerr_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_be          = be_q;
    assign data_out         = dout_q;
    assign reg_write_en_out = dwe_q;
    assign reg_addr_out     = dra_q;
    assign valid_out        = vout_q;
    assign align_err        = aerr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with a scoreboard queue checked by an output monitor.
`default_nettype none

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [31:0] store_data;
    logic [3:0]  mem_op;
    logic        reg_write_en_in;
    logic [4:0]  reg_addr_in;
    logic        stall_req;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] data_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_addr_out;
    logic        valid_out;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        we;
        logic [4:0]  ra;
        logic        ae;
    } exp_t;
    exp_t sb[$];

    mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .store_data(store_data), .mem_op(mem_op), .reg_write_en_in(reg_write_en_in),
        .reg_addr_in(reg_addr_in), .stall_req(stall_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .data_out(data_out), .reg_write_en_out(reg_write_en_out),
        .reg_addr_out(reg_addr_out), .valid_out(valid_out), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid_out must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("align_err", {31'd0, align_err}, {31'd0, e.ae});
                chk("reg_write_en_out", {31'd0, reg_write_en_out}, {31'd0, e.we});
                chk("reg_addr_out", {27'd0, reg_addr_out}, {27'd0, e.ra});
                if (!e.ae) chk("data_out", data_out, e.d);
            end
        end
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 after the instruction is retired.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic we, input logic [4:0] ra, input bit vld, input bit bus,
                       input int dly, input logic [31:0] rd, input logic [31:0] ed,
                       input logic ewe, input logic eae, input logic [3:0] ebe,
                       input logic [31:0] ewd, input bit st);
        exp_t e;
        valid_in = vld; mem_op = op; data_in = a; store_data = sd;
        reg_write_en_in = we; reg_addr_in = ra; dmem_ack = 1'b0;
        if (vld) begin
            e.d = ed; e.we = ewe; e.ra = ra; e.ae = eae;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("stall_idle", {31'd0, stall_req}, {31'd0, bus});
        @(posedge clk); #1;
        if (!bus) begin
            valid_in = 1'b0;
            chk("no_req", {31'd0, dmem_req}, 32'd0);
            return;
        end
        for (int i = 0; i <= dly; i++) begin
            if (i == dly) begin
                dmem_ack = 1'b1; dmem_rdata = rd;
            end
            @(negedge clk);
            chk("dmem_req", {31'd0, dmem_req}, 32'd1);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, st});
            chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
            chk("dmem_be", {28'd0, dmem_be}, {28'd0, ebe});
            if (st) chk("dmem_wdata", dmem_wdata, ewd);
            chk("stall_busy", {31'd0, stall_req}, (i == dly) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0; valid_in = 1'b0;
        chk("req_dropped", {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; store_data = '0; mem_op = '0;
        reg_write_en_in = 1'b0; reg_addr_in = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // op, addr, sdata, we, ra, vld, bus, dly, rdata, exp_data, exp_we, exp_ae, exp_be, exp_wdata, store
        run(4'd0, 32'h1234,      32'h0,         1, 5'd5,  1, 0, 0, 32'h0,         32'h1234,      1, 0, 4'b0000, 32'h0,         0);
        run(4'd1, 32'h103,       32'h0,         1, 5'd7,  1, 1, 0, 32'h80FF_0000, 32'hFFFF_FF80, 1, 0, 4'b1000, 32'h0,         0);
        run(4'd7, 32'h202,       32'hABCD_5678, 0, 5'd0,  1, 1, 3, 32'h0,         32'h202,       0, 0, 4'b1100, 32'h5678_5678, 1);
        run(4'd5, 32'h101,       32'h0,         1, 5'd9,  1, 0, 0, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         0);
        run(4'd2, 32'h101,       32'h0,         1, 5'd10, 1, 1, 1, 32'h1234_80AB, 32'h0000_0080, 1, 0, 4'b0010, 32'h0,         0);
        run(4'd3, 32'h102,       32'h0,         1, 5'd11, 1, 1, 0, 32'h8001_7FFF, 32'hFFFF_8001, 1, 0, 4'b1100, 32'h0,         0);
        run(4'd4, 32'h100,       32'h0,         1, 5'd12, 1, 1, 2, 32'h8001_9ABC, 32'h0000_9ABC, 1, 0, 4'b0011, 32'h0,         0);
        run(4'd5, 32'h104,       32'h0,         1, 5'd13, 1, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h0,         0);
        run(4'd6, 32'h301,       32'h1122_3344, 1, 5'd14, 1, 1, 0, 32'h0,         32'h301,       1, 0, 4'b0010, 32'h4444_4444, 1);
        run(4'd8, 32'h300,       32'hCAFE_F00D, 0, 5'd15, 1, 1, 1, 32'h0,         32'h300,       0, 0, 4'b1111, 32'hCAFE_F00D, 1);
        run(4'd7, 32'h203,       32'h0,         1, 5'd16, 1, 0, 0, 32'h0,         32'h0,         0, 1, 4'b0000, 32'h0,         0);
        run(4'd9, 32'h5555_AAAA, 32'h0,         1, 5'd17, 1, 0, 0, 32'h0,         32'h5555_AAAA, 1, 0, 4'b0000, 32'h0,         0);
        run(4'd5, 32'h800,       32'h0,         1, 5'd18, 0, 0, 0, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         0);

        // Ack while idle must be ignored.
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);

        // Reset during an outstanding LW discards it.
        valid_in = 1'b1; mem_op = 4'd5; data_in = 32'h700; reg_write_en_in = 1'b1; reg_addr_in = 5'd20;
        @(posedge clk); #1;
        chk("busy_req", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'd0, dmem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        begin
            exp_t e;
            int n;
            e.d = 32'h0; e.we = 1'b0; e.ra = 5'd21; e.ae = 1'b1;
            sb.push_back(e);
            valid_in = 1'b1; mem_op = 4'd5; data_in = 32'h400; reg_write_en_in = 1'b1; reg_addr_in = 5'd21;
            @(posedge clk); #1;
            valid_in = 1'b0;
            n = 0;
            while (dmem_req && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("timeout_busy_cycles", n, 32'd16);
        end
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
